pipe_adder_n: RTL and testbench

Parametrised, pipelined N-bit adder/subtractor with a valid/ready handshake. It is the successor to the fixed 4-bit ripple-carry adder. The carry chain is split into STAGES equal slices with one register stage per slice, so WIDTH scales without a long combinational carry path. It sits between operand-producing datapath blocks and result consumers, and accepts one operation per cycle at full throughput.

---
 rtl/pipe_adder_n.sv | 89 ++++++++
 tb/tb_pipe_adder_n.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder_n.sv
// Pipelined WIDTH-bit adder/subtractor, one SW-bit carry slice per stage, valid/ready handshake.
// Define PIPE_ADDER_OVF_EN to compile in signed-overflow tracking; otherwise ovf is tied to 0.
module pipe_adder_n #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);

   localparam int unsigned SW   = WIDTH / STAGES;
   localparam int unsigned SW1  = SW + 1;
   localparam int unsigned LAST = STAGES - 1;
   localparam int unsigned MSB  = WIDTH - 1;

   logic             advance_c;
   logic [STAGES-1:0] pv;
   logic [STAGES-1:0] pc;
   logic [WIDTH-1:0] pa [STAGES];
   logic [WIDTH-1:0] pb [STAGES];
   logic [WIDTH-1:0] ps [STAGES];

   logic [SW:0]       sl [STAGES];
   logic [WIDTH-1:0]  ns [STAGES];
   logic [STAGES-1:0] nc;

   assign advance_c = !out_valid || out_ready;
   assign in_ready  = !rst && advance_c;

   // Each stage adds its own slice using the carry handed over by the previous stage.
   always_comb begin
      for (int k = 0; k < int'(STAGES); k++) begin
         sl[k] = {1'b0, pa[k][k*SW +: SW]} + {1'b0, pb[k][k*SW +: SW]} + SW1'(pc[k]);
         ns[k] = ps[k];
         ns[k][k*SW +: SW] = sl[k][SW-1:0];
         nc[k] = sl[k][SW];
      end
   end

   // Whole pipeline, including the output register, shifts together on advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pv        <= '0;
         pc        <= '0;
         for (int k = 0; k < int'(STAGES); k++) begin
            pa[k] <= '0;
            pb[k] <= '0;
            ps[k] <= '0;
         end
         out_valid <= 1'b0;
         s         <= '0;
         co        <= 1'b0;
         ovf       <= 1'b0;
      end else if (advance_c) begin
         pv[0] <= in_valid;
         pa[0] <= a;
         pb[0] <= sub ? ~b : b;
         pc[0] <= sub | cin;
         ps[0] <= '0;
         for (int k = 1; k < int'(STAGES); k++) begin
            pv[k] <= pv[k-1];
            pa[k] <= pa[k-1];
            pb[k] <= pb[k-1];
            ps[k] <= ns[k-1];
            pc[k] <= nc[k-1];
         end
         out_valid <= pv[LAST];
         s         <= ns[LAST];
         co        <= nc[LAST];
`ifdef PIPE_ADDER_OVF_EN
         ovf <= (pa[LAST][MSB] == pb[LAST][MSB]) && (ns[LAST][MSB] != pa[LAST][MSB]);
`else
         ovf <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_pipe_adder_n.sv
// Scoreboard bench for pipe_adder_n: accepted beats push hand-computed results, an output monitor pops and compares.
module tb_pipe_adder_n;

   localparam int unsigned WIDTH  = 16;
   localparam int unsigned STAGES = 4;
`ifdef PIPE_ADDER_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             sub = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] s;
   logic             co;
   logic             ovf;

   pipe_adder_n #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .co(co), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] s;
      logic        co;
      logic        ovf;
      logic [31:0] acc;
      logic        lat;
      logic        gap;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_out = -100;

   logic [15:0] exp_s = '0;
   logic        exp_co = 1'b0;
   logic        exp_ovf = 1'b0;
   logic        exp_lat = 1'b0;
   logic        exp_gap = 1'b0;

   // a, b, cin, sub, expected s, co, signed overflow
   logic [15:0] va   [15] = '{16'hFFFF, 16'h0005, 16'h0007, 16'h7FFF, 16'h1234, 16'h00FF, 16'h8000,
                              16'h0F0F, 16'h8000, 16'h0000, 16'hABCD, 16'h0001, 16'h4000, 16'hFFFF, 16'h1234};
   logic [15:0] vb   [15] = '{16'h0001, 16'h0007, 16'h0005, 16'h0001, 16'h1111, 16'h0001, 16'h8000,
                              16'hF0F0, 16'h0001, 16'h0000, 16'h1234, 16'h0002, 16'h4000, 16'hFFFF, 16'h0001};
   logic        vc   [15] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0};
   logic        vsub [15] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0};
   logic [15:0] vs   [15] = '{16'h0000, 16'hFFFE, 16'h0002, 16'h8000, 16'h2345, 16'h0101, 16'h0000,
                              16'h0000, 16'h7FFF, 16'h0000, 16'hBE01, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h1235};
   logic        vco  [15] = '{1, 0, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 0};
   logic        vov  [15] = '{0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Input side pushes the expected result of every accepted beat; output side pops and compares.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && in_valid && in_ready)
         q.push_back('{s: exp_s, co: exp_co, ovf: exp_ovf, acc: 32'(cyc + 1), lat: exp_lat, gap: exp_gap});
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_output", 32'(s), 32'hDEAD);
         end else begin
            e = q.pop_front();
            chk("sum", 32'(s), 32'(e.s));
            chk("carry_out", 32'(co), 32'(e.co));
            chk("overflow", 32'(ovf), 32'(e.ovf));
            if (e.lat) chk("latency", 32'(cyc) - e.acc, 32'(STAGES));
            if (e.gap) chk("throughput_gap", 32'(cyc - last_out), 32'd1);
         end
         last_out = cyc;
      end
   end

   task automatic set_beat(input int i, input bit lat, input bit gap);
      a       = va[i];
      b       = vb[i];
      cin     = vc[i];
      sub     = vsub[i];
      exp_s   = vs[i];
      exp_co  = vco[i];
      exp_ovf = vov[i] & OVF_EN;
      exp_lat = lat;
      exp_gap = gap;
      in_valid = 1'b1;
   endtask

   task automatic send(input int i, input bit lat, input bit gap);
      bit ok;
      ok = 1'b0;
      set_beat(i, lat, gap);
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 60 && q.size() != 0; t++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      chk("drain_pending", 32'(q.size()), 32'd0);
   endtask

   initial begin
      bit seen;
      // Reset state
      #1;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd0);
      chk("reset_s", 32'(s), 32'd0);
      chk("reset_co_ovf", 32'({co, ovf}), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("ready_after_reset", 32'(in_ready), 32'd1);

      // Directed single beats: carry through all slices, subtract with/without borrow, overflow
      for (int i = 0; i < 4; i++) begin
         send(i, 1'b1, 1'b0);
         idle();
         drain();
      end

      // Eight back-to-back beats at full throughput
      for (int i = 4; i < 12; i++) send(i, 1'b0, i != 4);
      idle();
      drain();

      // Backpressure: fill with out_ready low, then hold stalled for 5 cycles
      out_ready = 1'b0;
      for (int i = 12; i < 14; i++) send(i, 1'b0, 1'b0);
      send(4, 1'b0, 1'b0);
      send(5, 1'b0, 1'b0);
      idle();
      seen = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      chk("stall_result_pending", 32'(seen), 32'd1);
      @(posedge clk);
      #1;
      set_beat(6, 1'b0, 1'b0);
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         if (q.size() != 0) chk("stall_s_held", 32'(s), 32'(q[0].s));
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(6, 1'b0, 1'b0);
      idle();
      drain();

      // Reset with three beats in flight
      for (int i = 7; i < 10; i++) send(i, 1'b0, 1'b0);
      idle();
      rst = 1'b1;
      #1;
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_s", 32'(s), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd0);
      q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      send(14, 1'b1, 1'b0);
      idle();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
